// File: rtl/operand_queue_credit_arbiter_pkg.sv
// Shared definitions for the lane operand-queue credit arbiter.
// Provides the operand queue indices, queue count, credit counter type and
// the per-queue buffer depth vector. The operand queues stage and the
// arbiter both read the depths from here so they can never disagree.
package operand_queue_credit_arbiter_pkg;

    typedef enum logic [3:0] {
        AluA,
        AluB,
        MulFPUA,
        MulFPUB,
        MulFPUC,
        StA,
        SlideAddrGenA,
        MaskB,
        MaskM
    } opqueue_e;

    localparam int unsigned NrOperandQueues = 9;
    localparam int unsigned OpCntWidth      = 3;

    typedef logic [OpCntWidth-1:0] credit_t;

    // Index NrOperandQueues-1 (MaskM) down to 0 (AluA).
    localparam credit_t [NrOperandQueues-1:0] OpQueueDepth = {
        3'd1, 3'd1, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5
    };

endpackage

// File: rtl/operand_queue_credit_arbiter_rr_prio.sv
// Round-robin arbiter with a strict-priority override.
// Ports:
//   en_i       - allow a grant this cycle
//   req_i      - eligible requests
//   prio_i     - priority mask; eligible priority requests win, lowest index first
//   ptr_i      - current round-robin pointer
//   gnt_o      - one-hot grant or zero
//   next_ptr_o - pointer for the next cycle (granted+1 on a round-robin grant)
module operand_queue_credit_arbiter_rr_prio #(
    parameter  int unsigned NrReq    = 9,
    localparam int unsigned PtrWidth = (NrReq > 1) ? $clog2(NrReq) : 1
) (
    input  logic                en_i,
    input  logic [NrReq-1:0]    req_i,
    input  logic [NrReq-1:0]    prio_i,
    input  logic [PtrWidth-1:0] ptr_i,
    output logic [NrReq-1:0]    gnt_o,
    output logic [PtrWidth-1:0] next_ptr_o
);

    logic [NrReq-1:0] prio_req;
    logic [NrReq-1:0] hi_mask;
    logic [NrReq-1:0] hi_req;
    logic [NrReq-1:0] pick_src;
    logic [NrReq-1:0] pick;

    always_comb begin
        prio_req = req_i & prio_i;
        // Requests at or above the pointer; if none, the plain request
        // vector provides the wrap-around to index 0.
        hi_mask  = ~((NrReq'(1) << ptr_i) - NrReq'(1));
        hi_req   = req_i & hi_mask;

        if (|prio_req) begin
            pick_src = prio_req;
        end else if (|hi_req) begin
            pick_src = hi_req;
        end else begin
            pick_src = req_i;
        end

        // Isolate the lowest set bit.
        pick  = pick_src & (~pick_src + NrReq'(1));
        gnt_o = en_i ? pick : '0;

        next_ptr_o = ptr_i;
        if (en_i && !(|prio_req) && (|req_i)) begin
            for (int q = 0; q < int'(NrReq); q++) begin
                if (pick[q]) begin
                    next_ptr_o = (q == int'(NrReq) - 1) ? '0 : PtrWidth'(q + 1);
                end
            end
        end
    end

endmodule

// File: rtl/operand_queue_credit_arbiter.sv
// Shares the lane's single VRF operand read slot among the operand queues.
// Each queue holds a credit counter equal to its free buffer space; credits
// are taken at issue, so a read in flight already owns its slot.
// Ports:
//   clk_i, rst_i - clock, synchronous active-high reset
//   req_i        - queue has an element ready to read from the VRF
//   prio_i       - strict-priority mask
//   stall_i      - VRF read slot unavailable this cycle
//   gnt_o        - one-hot/zero issue grant (drives operand_issued_i)
//   consume_i    - queue output handshake, returns one credit
//   flush_i      - queue discarded, credits restore to depth
//   credits_o    - registered credit count per queue
//   err_o        - sticky credit-overflow error
module operand_queue_credit_arbiter
    import operand_queue_credit_arbiter_pkg::*;
#(
    parameter int unsigned NrQueues = NrOperandQueues,
    parameter int unsigned CntWidth = OpCntWidth,
    parameter logic [NrQueues-1:0][CntWidth-1:0] QueueDepth = OpQueueDepth
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NrQueues-1:0]                req_i,
    input  logic [NrQueues-1:0]                prio_i,
    input  logic                               stall_i,
    output logic [NrQueues-1:0]                gnt_o,
    input  logic [NrQueues-1:0]                consume_i,
    input  logic [NrQueues-1:0]                flush_i,
    output logic [NrQueues-1:0][CntWidth-1:0] credits_o,
    output logic                               err_o
);

    localparam int unsigned PtrWidth = (NrQueues > 1) ? $clog2(NrQueues) : 1;

    logic [CntWidth-1:0] credits_q [NrQueues];
    logic [NrQueues-1:0] has_credit;
    logic [NrQueues-1:0] elig;
    logic [NrQueues-1:0] gnt;
    logic [NrQueues-1:0] overflow;
    logic [PtrWidth-1:0] ptr_q;
    logic [PtrWidth-1:0] ptr_next;
    logic                err_q;
    logic                arb_en;

    assign arb_en = ~stall_i & ~rst_i;
    // consume_i deliberately does not feed eligibility: a returned credit
    // becomes visible only through the register on the following cycle.
    assign elig   = req_i & has_credit & ~flush_i;

    operand_queue_credit_arbiter_rr_prio #(
        .NrReq (NrQueues)
    ) i_arb (
        .en_i       (arb_en),
        .req_i      (elig),
        .prio_i     (prio_i),
        .ptr_i      (ptr_q),
        .gnt_o      (gnt),
        .next_ptr_o (ptr_next)
    );

    assign gnt_o = gnt;
    assign err_o = err_q;

    for (genvar q = 0; q < int'(NrQueues); q++) begin : g_credit
        assign has_credit[q] = (credits_q[q] != '0);
        assign credits_o[q]  = credits_q[q];
        // A consume with no matching grant while already full means the
        // queue returned a credit it never took.
        assign overflow[q]   = consume_i[q] & ~gnt[q] & ~flush_i[q]
                             & (credits_q[q] >= QueueDepth[q]);

        always_ff @(posedge clk_i) begin
            if (rst_i || flush_i[q]) begin
                credits_q[q] <= QueueDepth[q];
            end else if (gnt[q] && !consume_i[q]) begin
                credits_q[q] <= credits_q[q] - CntWidth'(1);
            end else if (!gnt[q] && consume_i[q] && !overflow[q]) begin
                credits_q[q] <= credits_q[q] + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_next;
            if (|overflow) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_operand_queue_credit_arbiter.sv
module tb_operand_queue_credit_arbiter;

    localparam int N = 9;
    localparam int W = 3;
    localparam logic [N-1:0][W-1:0] DEPTH = {
        3'd1, 3'd1, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5
    };

    logic                clk = 1'b0;
    logic                rst_i;
    logic [N-1:0]        req_i;
    logic [N-1:0]        prio_i;
    logic                stall_i;
    logic [N-1:0]        gnt_o;
    logic [N-1:0]        consume_i;
    logic [N-1:0]        flush_i;
    logic [N-1:0][W-1:0] credits_o;
    logic                err_o;

    always #5 clk = ~clk;

    operand_queue_credit_arbiter dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .prio_i    (prio_i),
        .stall_i   (stall_i),
        .gnt_o     (gnt_o),
        .consume_i (consume_i),
        .flush_i   (flush_i),
        .credits_o (credits_o),
        .err_o     (err_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: free slots per queue, round-robin start index, error flag.
    int m_cred [N];
    int m_ptr;
    bit m_err;

    function automatic logic [N-1:0] model_gnt();
        bit el [N];
        if (rst_i || stall_i) return '0;
        for (int q = 0; q < N; q++) el[q] = req_i[q] && (m_cred[q] > 0) && !flush_i[q];
        for (int q = 0; q < N; q++) if (el[q] && prio_i[q]) return N'(1) << q;
        for (int i = 0; i < N; i++) begin
            int q;
            q = (m_ptr + i) % N;
            if (el[q]) return N'(1) << q;
        end
        return '0;
    endfunction

    task automatic tick();
        logic [N-1:0] g;
        g = model_gnt();
        @(posedge clk);
        if (rst_i) begin
            for (int q = 0; q < N; q++) m_cred[q] = int'(DEPTH[q]);
            m_ptr = 0;
            m_err = 1'b0;
        end else begin
            for (int q = 0; q < N; q++) begin
                if (flush_i[q]) m_cred[q] = int'(DEPTH[q]);
                else if (g[q] && consume_i[q]) m_cred[q] = m_cred[q];
                else if (g[q]) m_cred[q] = m_cred[q] - 1;
                else if (consume_i[q]) begin
                    if (m_cred[q] >= int'(DEPTH[q])) m_err = 1'b1;
                    else m_cred[q] = m_cred[q] + 1;
                end
            end
            if (g != '0 && (g & prio_i) == '0)
                for (int q = 0; q < N; q++) if (g[q]) m_ptr = (q + 1) % N;
        end
        #1;
    endtask

    task automatic idle_inputs();
        req_i = '0; prio_i = '0; stall_i = 1'b0; consume_i = '0; flush_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        req_i = '1;
        rst_i = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (gnt_o !== '0) begin
            failures++; $display("FAIL reset_gnt actual=%b required=0", gnt_o);
        end
        for (int q = 0; q < N; q++) begin
            checks++;
            if (credits_o[q] !== DEPTH[q]) begin
                failures++;
                $display("FAIL reset_credits q=%0d actual=%0d required=%0d", q, credits_o[q], DEPTH[q]);
            end
        end
        checks++;
        if (err_o !== 1'b0) begin
            failures++; $display("FAIL reset_err actual=%b required=0", err_o);
        end
        rst_i = 1'b0;
        idle_inputs();
        #1;
    endtask

    task automatic test_round_robin();
        do_reset();
        req_i = '1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (gnt_o !== (N'(1) << i) || gnt_o !== model_gnt()) begin
                failures++; $display("FAIL rr_gnt step=%0d actual=%b required=%b", i, gnt_o, N'(1) << i);
            end
            tick();
        end
        for (int q = 0; q < 4; q++) begin
            checks++;
            if (int'(credits_o[q]) !== (q < 3 ? 4 : 5)) begin
                failures++;
                $display("FAIL rr_credits q=%0d actual=%0d required=%0d", q, credits_o[q], (q < 3 ? 4 : 5));
            end
        end
        #1;
        checks++;
        if (gnt_o !== (N'(1) << 3)) begin
            failures++; $display("FAIL rr_pointer actual=%b required=%b", gnt_o, N'(1) << 3);
        end
        idle_inputs();
    endtask

    task automatic test_credit_exhaustion();
        do_reset();
        req_i = N'(1) << 7;
        #1;
        checks++;
        if (gnt_o !== (N'(1) << 7)) begin
            failures++; $display("FAIL exh_first actual=%b required=%b", gnt_o, N'(1) << 7);
        end
        tick();
        checks++;
        if (gnt_o !== '0 || credits_o[7] !== 3'd0) begin
            failures++; $display("FAIL exh_empty gnt=%b credits=%0d required gnt=0 credits=0", gnt_o, credits_o[7]);
        end
        consume_i = N'(1) << 7;
        #1;
        checks++;
        if (gnt_o !== '0) begin
            failures++; $display("FAIL exh_consume_same_cycle actual=%b required=0", gnt_o);
        end
        tick();
        consume_i = '0;
        #1;
        checks++;
        if (gnt_o !== (N'(1) << 7) || credits_o[7] !== 3'd1) begin
            failures++; $display("FAIL exh_regrant gnt=%b credits=%0d required gnt=%b credits=1", gnt_o, credits_o[7], N'(1) << 7);
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        do_reset();
        req_i  = (N'(1) << 0) | (N'(1) << 5) | (N'(1) << 8);
        prio_i = N'(1) << 5;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (gnt_o !== (N'(1) << 5)) begin
                failures++; $display("FAIL prio_gnt step=%0d actual=%b required=%b", i, gnt_o, N'(1) << 5);
            end
            tick();
        end
        #1;
        checks++;
        if (gnt_o !== (N'(1) << 0) || credits_o[5] !== 3'd0) begin
            failures++; $display("FAIL prio_ptr_hold gnt=%b credits5=%0d required gnt=%b credits5=0", gnt_o, credits_o[5], N'(1) << 0);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_simultaneous_stall();
        do_reset();
        req_i = N'(1) << 0;
        tick();
        tick();
        consume_i = N'(1) << 0;
        #1;
        checks++;
        if (gnt_o !== (N'(1) << 0)) begin
            failures++; $display("FAIL sim_gnt actual=%b required=%b", gnt_o, N'(1) << 0);
        end
        tick();
        checks++;
        if (credits_o[0] !== 3'd3) begin
            failures++; $display("FAIL sim_credits actual=%0d required=3", credits_o[0]);
        end
        consume_i = '0;
        req_i = '1;
        stall_i = 1'b1;
        #1;
        checks++;
        if (gnt_o !== '0) begin
            failures++; $display("FAIL stall_gnt actual=%b required=0", gnt_o);
        end
        tick();
        for (int q = 0; q < N; q++) begin
            checks++;
            if (int'(credits_o[q]) !== (q == 0 ? 3 : int'(DEPTH[q]))) begin
                failures++; $display("FAIL stall_credits q=%0d actual=%0d", q, credits_o[q]);
            end
        end
        stall_i = 1'b0;
        #1;
        checks++;
        if (gnt_o !== (N'(1) << 1)) begin
            failures++; $display("FAIL stall_ptr actual=%b required=%b", gnt_o, N'(1) << 1);
        end
        idle_inputs();
    endtask

    task automatic test_flush_overflow();
        do_reset();
        req_i = N'(1) << 2;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (credits_o[2] !== 3'd1) begin
            failures++; $display("FAIL flush_pre actual=%0d required=1", credits_o[2]);
        end
        flush_i   = N'(1) << 2;
        consume_i = N'(1) << 2;
        #1;
        checks++;
        if (gnt_o !== '0) begin
            failures++; $display("FAIL flush_gnt actual=%b required=0", gnt_o);
        end
        tick();
        checks++;
        if (credits_o[2] !== 3'd5 || err_o !== 1'b0) begin
            failures++; $display("FAIL flush_credits credits=%0d err=%b required credits=5 err=0", credits_o[2], err_o);
        end
        flush_i = '0;
        req_i   = '0;
        tick();
        consume_i = '0;
        checks++;
        if (credits_o[2] !== 3'd5 || err_o !== 1'b1) begin
            failures++; $display("FAIL overflow credits=%0d err=%b required credits=5 err=1", credits_o[2], err_o);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (err_o !== 1'b1) begin
            failures++; $display("FAIL err_sticky actual=%b required=1", err_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++;
        if (err_o !== 1'b0) begin
            failures++; $display("FAIL err_reset actual=%b required=0", err_o);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_i   = N'($urandom);
            prio_i  = N'($urandom & $urandom & $urandom);
            stall_i = ($urandom_range(7) == 0);
            flush_i = ($urandom_range(15) == 0) ? (N'(1) << $urandom_range(N - 1)) : '0;
            consume_i = '0;
            for (int q = 0; q < N; q++)
                if (m_cred[q] < int'(DEPTH[q]) && $urandom_range(1) == 1) consume_i[q] = 1'b1;
            if ($urandom_range(31) == 0) consume_i[$urandom_range(N - 1)] = 1'b1;
            rst_i = ($urandom_range(63) == 0);
            #1;
            checks++;
            if (gnt_o !== model_gnt()) begin
                failures++; $display("FAIL rand_gnt cycle=%0d actual=%b required=%b", c, gnt_o, model_gnt());
            end
            tick();
            for (int q = 0; q < N; q++) begin
                checks++;
                if (int'(credits_o[q]) !== m_cred[q]) begin
                    failures++; $display("FAIL rand_credits cycle=%0d q=%0d actual=%0d required=%0d", c, q, credits_o[q], m_cred[q]);
                end
            end
            checks++;
            if (err_o !== m_err) begin
                failures++; $display("FAIL rand_err cycle=%0d actual=%b required=%b", c, err_o, m_err);
            end
        end
        rst_i = 1'b0;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        for (int q = 0; q < N; q++) m_cred[q] = int'(DEPTH[q]);
        m_ptr = 0;
        m_err = 1'b0;
        test_reset();
        test_round_robin();
        test_credit_exhaustion();
        test_priority();
        test_simultaneous_stall();
        test_flush_overflow();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
